// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier bit or quotient bit per cycle; signs are applied in a final fix-up cycle.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;
   logic                 pend_q, pend_d;
   logic                 pend_dbz_q, pend_dbz_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;
   logic                 rneg_q, rneg_d;

   logic                 op_signed;
   logic [WIDTH-1:0]     rs_abs, rt_abs;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;
   logic                 last_iter;

   assign op_signed = (op == OpMult) || (op == OpDiv);
   assign rs_abs    = (op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign rt_abs    = (op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

   // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
   // Divide: dividend bits leave acc's top while quotient bits enter at the bottom.
   assign div_shift = {rem_q, acc_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};

   assign prod_fix  = neg_q ? -acc_q : acc_q;
   assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = rneg_q ? -rem_q : rem_q;
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = pend_q;
      dbz_d      = pend_dbz_q;
      pend_d     = 1'b0;
      pend_dbz_d = 1'b0;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;

      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               case (op)
                  OpMult, OpMultu: begin
                     mcand_d  = rs_abs;
                     acc_d    = {{WIDTH{1'b0}}, rt_abs};
                     neg_d    = op_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                     is_div_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = StMul;
                  end
                  OpDiv, OpDivu: begin
                     if (rt_data == '0) begin
                        pend_d     = 1'b1;
                        pend_dbz_d = 1'b1;
                     end else begin
                        mcand_d  = rt_abs;
                        acc_d    = {{WIDTH{1'b0}}, rs_abs};
                        rem_d    = '0;
                        neg_d    = op_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        rneg_d   = op_signed && rs_data[WIDTH-1];
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = StDiv;
                     end
                  end
                  OpMthi: begin
                     hi_d   = rs_data;
                     pend_d = 1'b1;
                  end
                  OpMtlo: begin
                     lo_d   = rs_data;
                     pend_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         StMul: begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) state_d = StFix;
         end
         StDiv: begin
            if (div_diff[WIDTH+1]) begin
               rem_d              = div_shift[WIDTH-1:0];
               acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d              = div_diff[WIDTH-1:0];
               acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) state_d = StFix;
         end
         StFix: begin
            if (is_div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Cancel wins over any completion scheduled for this edge.
      if (flush && busy) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_dbz_q <= 1'b0;
         mcand_q    <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
         pend_q     <= pend_d;
         pend_dbz_q <= pend_dbz_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed, random, flush, reset and back-to-back scenarios
// against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int unsigned W = 32;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  rs_data = '0;
   logic [W-1:0]  rt_data = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state and expectations for the most recent op
   logic [W-1:0]  m_hi = '0;
   logic [W-1:0]  m_lo = '0;
   int            exp_lat;
   int            exp_busy;
   logic          exp_dbz;

   mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint     sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      exp_dbz  = 1'b0;
      exp_lat  = W + 1;
      exp_busy = W + 1;
      case (o)
         3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2, 3'd3: begin
            if (b == '0) begin
               exp_dbz = 1'b1; exp_lat = 1; exp_busy = 0;
            end else if (o == 3'd2) begin
               m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
            end else begin
               m_lo = a / b; m_hi = a % b;
            end
         end
         3'd4: begin m_hi = a; exp_lat = 1; exp_busy = 0; end
         3'd5: begin m_lo = a; exp_lat = 1; exp_busy = 0; end
         default: begin exp_lat = -1; exp_busy = 0; end
      endcase
   endtask

   // Issue one op and wait (bounded) for done; lat counts edges after the start edge.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt, output logic [W-1:0] h,
                         output logic [W-1:0] l, output logic z);
      op = o; rs_data = a; rt_data = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1; bcnt = 0; h = hi; l = lo; z = div_by_zero;
      for (int i = 0; i <= 40; i++) begin
         if (done) begin
            lat = i; h = hi; l = lo; z = div_by_zero;
            break;
         end
         if (busy) bcnt++;
         @(posedge clock); #1;
      end
      if (lat < 0) begin h = hi; l = lo; z = div_by_zero; end
   endtask

   task automatic test_reset();
      #12;
      n_cmp += 5;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
      if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
      if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_directed();
      logic [2:0]   d_op [10] = '{3'd1, 3'd0, 3'd2, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5, 3'd3};
      logic [W-1:0] d_rs [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000,
                                  32'h00001234, 32'd9, 32'd1, 32'd1, 32'h0000CAFE, 32'hFFFFFFFF};
      logic [W-1:0] d_rt [10] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'hFFFFFFFF,
                                  32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1};
      int lat, bcnt;
      logic [W-1:0] h, l;
      logic z;
      for (int k = 0; k < 10; k++) begin
         model_op(d_op[k], d_rs[k], d_rt[k]);
         run_op(d_op[k], d_rs[k], d_rt[k], lat, bcnt, h, l, z);
         n_cmp += 5;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, exp_lat); end
         if (bcnt !== exp_busy) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", k, bcnt, exp_busy); end
         if (h !== m_hi) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", k, h, m_hi); end
         if (l !== m_lo) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", k, l, m_lo); end
         if (z !== exp_dbz) begin n_fail++; $display("FAIL dir%0d_dbz got %b want %b", k, z, exp_dbz); end
         if (lat >= 0) begin
            @(posedge clock); #1;
            n_cmp += 2;
            if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", k, done); end
            if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dbz_low got %b want 0", k, div_by_zero); end
         end
      end
   endtask

   task automatic test_random();
      int lat, bcnt;
      logic [W-1:0] h, l, a, b;
      logic [2:0] o;
      logic z;
      for (int k = 0; k < 24; k++) begin
         o = 3'($urandom_range(0, 5));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
         model_op(o, a, b);
         run_op(o, a, b, lat, bcnt, h, l, z);
         n_cmp += 4;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency op %0d got %0d want %0d", k, o, lat, exp_lat); end
         if (h !== m_hi) begin n_fail++; $display("FAIL rnd%0d_hi op %0d %h,%h got %h want %h", k, o, a, b, h, m_hi); end
         if (l !== m_lo) begin n_fail++; $display("FAIL rnd%0d_lo op %0d %h,%h got %h want %h", k, o, a, b, l, m_lo); end
         if (z !== exp_dbz) begin n_fail++; $display("FAIL rnd%0d_dbz got %b want %b", k, z, exp_dbz); end
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
   endtask

   task automatic test_flush();
      int dones = 0;
      op = 3'd1; rs_data = 32'h0000ABCD; rt_data = 32'h00012345; start = 1'b1;
      @(posedge clock); #1;                       // E0
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      op = 3'd4; rs_data = 32'hDEADBEEF; start = 1'b1;   // sampled at E0+5 while busy
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      flush = 1'b1;                               // sampled at E0+10
      @(posedge clock); #1;
      flush = 1'b0;
      n_cmp += 4;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", done); end
      if (hi !== m_hi) begin n_fail++; $display("FAIL flush_hi got %h want %h", hi, m_hi); end
      if (lo !== m_lo) begin n_fail++; $display("FAIL flush_lo got %h want %h", lo, m_lo); end
      repeat (40) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      n_cmp += 2;
      if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d want 0", dones); end
      if (hi !== m_hi) begin n_fail++; $display("FAIL flush_hi_later got %h want %h", hi, m_hi); end
   endtask

   task automatic test_flush_idle();
      int dones = 0;
      op = 3'd5; rs_data = 32'hAAAA5555; start = 1'b1; flush = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; flush = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      n_cmp += 2;
      if (dones !== 0) begin n_fail++; $display("FAIL flush_idle_done got %0d want 0", dones); end
      if (lo !== m_lo) begin n_fail++; $display("FAIL flush_idle_lo got %h want %h", lo, m_lo); end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      logic [W-1:0] h, l;
      logic z;
      model_op(3'd3, 32'd100, 32'd7);
      run_op(3'd3, 32'd100, 32'd7, lat, bcnt, h, l, z);
      n_cmp += 3;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", lat, exp_lat); end
      if (h !== 32'd2) begin n_fail++; $display("FAIL b2b_first_hi got %h want 2", h); end
      if (l !== 32'd14) begin n_fail++; $display("FAIL b2b_first_lo got %h want 14", l); end
      model_op(3'd1, 32'd6, 32'd7);
      run_op(3'd1, 32'd6, 32'd7, lat, bcnt, h, l, z);   // start lands in the done cycle
      n_cmp += 3;
      if (lat !== W + 1) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", lat, W + 1); end
      if (h !== m_hi) begin n_fail++; $display("FAIL b2b_second_hi got %h want %h", h, m_hi); end
      if (l !== 32'd42) begin n_fail++; $display("FAIL b2b_second_lo got %h want 42", l); end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      op = 3'd1; rs_data = 32'h55; rt_data = 32'h77; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #4;
      reset_n = 1'b0;                             // before edge E0+10
      #1;
      n_cmp += 5;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
      if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rstmid_dbz got %b want 0", div_by_zero); end
      if (hi !== '0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", hi); end
      if (lo !== '0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", lo); end
      m_hi = '0; m_lo = '0;
      @(negedge clock); reset_n = 1'b1;
      repeat (40) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      n_cmp += 1;
      if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_flush_idle();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
